// File: rtl/uart_rx_monitor.sv
// UART receive monitor: synchronises rxd, decodes frames (5..8 data bits, optional
// parity, 1 or 2 stop bits) and queues {err, data} in a FIFO that drives n_cts.
module uart_rx_monitor #(
    parameter int CLK_PER_BIT   = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int CTS_THRESHOLD = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    output logic                        n_cts,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic [1:0]                  rd_err,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    input  logic                        clear_overflow,
    output logic [15:0]                 frame_count
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic             HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PAR       = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    // Handshake: an entry moves from the FIFO to the consumer on every clock
    // edge where rd_valid && rd_ready; the head holds steady otherwise.

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rs_q;
    logic rs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rxd;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 push_q;
    logic [DATA_BITS-1:0] push_data_q;
    logic [1:0]           push_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT_HIGH;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_err_q  <= '0;
        end else begin
            push_q <= 1'b0;
            unique case (state_q)
                S_WAIT_HIGH: begin
                    if (rs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!rs_q && rs_prev_q) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_CNT;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (!rs_q) begin
                            state_q   <= S_DATA;
                            cnt_q     <= FULL_CNT;
                            bit_cnt_q <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end else begin
                            // Line was back high at mid-start: treat as a glitch.
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rs_q, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_CNT;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            state_q   <= HAS_PAR ? S_PAR : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_PAR: begin
                    if (cnt_q == '0) begin
                        par_err_q <= ((^shift_q) ^ rs_q) != PAR_ODD;
                        cnt_q     <= FULL_CNT;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        cnt_q <= FULL_CNT;
                        if (bit_cnt_q == LAST_STOP) begin
                            push_q      <= 1'b1;
                            push_data_q <= shift_q;
                            push_err_q  <= {par_err_q, frm_err_q | ~rs_q};
                            bit_cnt_q   <= '0;
                            // A low final stop sample means break: wait for the line to recover.
                            state_q     <= rs_q ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            frm_err_q <= frm_err_q | ~rs_q;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_WAIT_HIGH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO, flow control and status
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic [LVL_W-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             n_cts_q;
    logic [15:0]      frame_count_q;
    logic             pop;
    logic             push_ok;
    logic [ENT_W-1:0] head;

    assign pop     = rd_valid && rd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_q && ((count_q < LVL_W'(FIFO_DEPTH)) || pop);
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - LVL_W'(1);
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (push_q && !push_ok) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_err_q, push_data_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            n_cts_q       <= 1'b1;
            frame_count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_q) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            n_cts_q    <= (count_d >= LVL_W'(CTS_THRESHOLD));
        end
    end

    assign rd_valid    = (count_q != '0);
    assign rd_data     = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_err      = rd_valid ? head[ENT_W-1 -: 2] : 2'b00;
    assign level       = count_q;
    assign overflow    = overflow_q;
    assign n_cts       = n_cts_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Parametrised, synthesizable UART receive monitor for the FPGA simulation harness and on-board loopback checks. It watches the DUT's serial output (`txd`) and decodes frames with configurable data width, parity and stop bits. Decoded bytes go into a FIFO together with per-frame error flags, and the block drives active-low CTS flow control from the FIFO level. It replaces the hard-wired `cts = 0` tie-off with real back-pressure and gives benches a self-checking capture path.

Parameters:
CLK_PER_BIT, 16, system clocks per bit; even, >= 4
DATA_BITS, 8, data bits per frame; 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, capture entries; power of 2, >= 2
CTS_THRESHOLD, 12, level at which n_cts deasserts; 1..FIFO_DEPTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rxd  in  1  serial line, asynchronous, idle high
n_cts  out  1  0 = sender may transmit
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer accepts head
rd_data  out  DATA_BITS  received data, LSB = first bit on wire
rd_err  out  2  [1] = parity error, [0] = framing error, for the head entry
level  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a frame was dropped because the FIFO was full
clear_overflow  in  1  clears overflow
frame_count  out  16  completed frames, including dropped ones; wraps at 65535 -> 0

Behaviour:
- Clock and reset: one clock (`clk`); reset is synchronous and active-high (`rst`). All state is clocked on `clk`.
- Synchronizer: 2-flop synchronizer on `rxd`, both flops reset to 1. All decode uses the synchronized value `rs`.
- Reset values: rd_valid=0, rd_data=0, rd_err=0, level=0, overflow=0, frame_count=0, n_cts=1. The FSM resets to WAIT_HIGH.
- n_cts timing: n_cts is registered. It is 1 when level >= CTS_THRESHOLD and 0 otherwise. It first drops the cycle after rst deasserts.
- Reset mid-frame: aborts the frame with no push and empties the FIFO.
- FSM states: WAIT_HIGH, IDLE, START, DATA, PAR, STOP.
  - WAIT_HIGH: stay until rs=1, then go to IDLE. This prevents a line held low out of reset from being taken as a start bit.
  - IDLE: a 1->0 transition on rs moves to START. The bit counter loads CLK_PER_BIT/2-1.
  - START: at counter expiry, sample rs. If 0, go to DATA and load CLK_PER_BIT-1. If 1, it was a glitch: return to IDLE with no push and no count.
  - DATA: sample at each expiry, shifting LSB first. After DATA_BITS samples, go to PAR if PARITY != 0, else STOP.
  - PAR: one sample. Parity error if (XOR of data bits XOR sample) != (PARITY==1 ? 1 : 0).
  - STOP: STOP_BITS samples. Any stop sample of 0 sets framing error.
- End of frame: on the final stop sample, push {err, data} on the next clock edge and increment frame_count. Then go to IDLE if the final sample was 1. If it was 0 (break or low line), go to WAIT_HIGH.
- Back-to-back frames: a start edge is detected immediately after the stop-bit midpoint, with no idle gap required.
- Latency: rd_valid rises exactly 2 + CLK_PER_BIT/2 + (DATA_BITS + (PARITY!=0) + STOP_BITS)*CLK_PER_BIT + 2 cycles after the `rxd` falling edge, assuming an empty FIFO. There is no fall-through path.
- FIFO handshake:
  - A pop occurs when rd_valid && rd_ready.
  - A push is accepted if level < FIFO_DEPTH or a pop occurs in the same cycle. With simultaneous push and pop, level is unchanged.
  - If a push is rejected, the entry is dropped and overflow is set.
  - If clear_overflow and a new overflow happen in the same cycle, the set wins.
  - rd_data and rd_err stay stable while rd_valid && !rd_ready.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Defaults (CLK_PER_BIT=16, 8N1): drive 0xA5 on rxd with an 8N1 frame -> rd_valid rises 156 cycles after the start edge; rd_data=0xA5, rd_err=00, frame_count=1.
2. PARITY=2, drive 0x07 with parity bit 0 (wrong) -> rd_err=10. Then 0x07 with parity bit 1 -> rd_err=00.
3. Stop bit driven 0, then the line held low for 40 bit times -> one entry with rd_err=01. No further frames until rxd returns high; a subsequent 0x3C decodes correctly.
4. rd_ready=0, send 17 frames 0x00..0x10 with FIFO_DEPTH=16, CTS_THRESHOLD=12:
   - n_cts=1 once level reaches 12.
   - Frame 0x10 is dropped: overflow=1, frame_count=17, level=16.
   - Draining yields 0x00..0x0F in order.
   - Pulse clear_overflow -> overflow=0.
5. A 3-cycle low glitch on rxd -> no push, frame_count unchanged. Assert rst midway through frame 0x55, with rxd held low -> FSM waits for high; level=0, n_cts=1 during rst; the next clean 0x55 is captured.
6. At level=16, assert rd_ready while a frame completes -> push is accepted, level stays 16, overflow stays 0.
